// File: rtl/config_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | config_pkg                                                           |
// | Shared data word types and the mac_unit state encoding.              |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package config_pkg;

  typedef logic [31:0] data_t;
  typedef logic [63:0] w_data_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL     = 3'd1,
    ADD     = 3'd2,
    SEND_HI = 3'd3,
    SEND_LO = 3'd4
  } mac_state_t;

endpackage
`default_nettype wire

// File: rtl/seq_mul.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seq_mul                                                              |
// | Unsigned shift-add multiplier, one multiplier bit per clock.         |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module seq_mul #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            arst_i,
  input  logic            start,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic            done,
  output logic [2*DW-1:0] product
);

  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] c_last = CW'(DW - 1);

  logic [2*DW-1:0] r_mcand;
  logic [DW-1:0]   r_mplier;
  logic [2*DW-1:0] r_acc;
  logic [CW-1:0]   r_cnt;
  logic            r_run;
  logic            r_done;

  // Always runs the full DW iterations; done is a registered one-cycle pulse.
  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_mcand  <= {{DW{1'b0}}, a};
        r_mplier <= b;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_run    <= 1'b1;
      end else if (r_run) begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        if (r_cnt == c_last) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign done    = r_done;
  assign product = r_acc;

endmodule
`default_nettype wire

// File: rtl/mac_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mac_unit                                                             |
// | Sequential a*b+c with a one-entry pending buffer and a two-word      |
// | valid/ready result serializer (high word first).                     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module mac_unit
  import config_pkg::*;
#(
  parameter int DW = $bits(data_t)
) (
  input  logic            clk,
  input  logic            arst_i,
  input  logic            operation_valid_i,
  input  logic [DW-1:0]   operand_a_i,
  input  logic [DW-1:0]   operand_b_i,
  input  logic [2*DW-1:0] operand_c_i,
  output logic [DW-1:0]   wr_data_o,
  output logic            wr_data_valid_o,
  input  logic            wr_data_ready_i,
  output logic            busy_o,
  output logic            drop_o
);

  mac_state_t      r_state;
  mac_state_t      w_state_nxt;

  logic [2*DW-1:0] r_c;
  logic [2*DW-1:0] r_acc;
  logic            r_pend_full;
  logic [DW-1:0]   r_pend_a;
  logic [DW-1:0]   r_pend_b;
  logic [2*DW-1:0] r_pend_c;
  logic            r_drop;

  logic            w_busy;
  logic            w_last_hs;
  logic            w_consume;
  logic            w_start;
  logic            w_accept;
  logic            w_store;
  logic            w_drop;
  logic [DW-1:0]   w_start_a;
  logic [DW-1:0]   w_start_b;
  logic [2*DW-1:0] w_start_c;
  logic            w_mul_done;
  logic [2*DW-1:0] w_product;

  assign w_busy    = (r_state != IDLE);
  assign w_last_hs = (r_state == SEND_LO) && wr_data_ready_i;

  // A pending entry is also drained from IDLE: an op landing on the final
  // handshake of an empty-pending run would otherwise be stranded there.
  assign w_consume = r_pend_full && ((r_state == IDLE) || w_last_hs);
  assign w_start   = w_consume || ((r_state == IDLE) && operation_valid_i);
  assign w_start_a = w_consume ? r_pend_a : operand_a_i;
  assign w_start_b = w_consume ? r_pend_b : operand_b_i;
  assign w_start_c = w_consume ? r_pend_c : operand_c_i;

  assign w_accept  = operation_valid_i && (w_busy || w_consume);
  assign w_store   = w_accept && (!r_pend_full || w_consume);
  assign w_drop    = w_accept && r_pend_full && !w_consume;

  seq_mul #(
    .DW (DW)
  ) u_seq_mul (
    .clk     (clk),
    .arst_i  (arst_i),
    .start   (w_start),
    .a       (w_start_a),
    .b       (w_start_b),
    .done    (w_mul_done),
    .product (w_product)
  );

  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    wr_data_o       = '0;
    wr_data_valid_o = 1'b0;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = MUL;
      MUL:     if (w_mul_done) w_state_nxt = ADD;
      ADD:     w_state_nxt = SEND_HI;
      SEND_HI: begin
        wr_data_valid_o = 1'b1;
        wr_data_o       = r_acc[2*DW-1:DW];
        if (wr_data_ready_i) w_state_nxt = SEND_LO;
      end
      SEND_LO: begin
        wr_data_valid_o = 1'b1;
        wr_data_o       = r_acc[DW-1:0];
        if (wr_data_ready_i) w_state_nxt = w_consume ? MUL : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      r_c         <= '0;
      r_acc       <= '0;
      r_pend_full <= 1'b0;
      r_pend_a    <= '0;
      r_pend_b    <= '0;
      r_pend_c    <= '0;
      r_drop      <= 1'b0;
    end else begin
      r_drop <= w_drop;
      if (w_start) begin
        r_c <= w_start_c;
      end
      if (r_state == ADD) begin
        r_acc <= w_product + r_c;
      end
      if (w_store) begin
        r_pend_full <= 1'b1;
        r_pend_a    <= operand_a_i;
        r_pend_b    <= operand_b_i;
        r_pend_c    <= operand_c_i;
      end else if (w_consume) begin
        r_pend_full <= 1'b0;
      end
    end
  end

  assign busy_o = w_busy;
  assign drop_o = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_mac_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mac_unit                                                          |
// | Directed and randomized checks of mac_unit against an a*b+c model.   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_mac_unit;

  localparam int DW = 32;

  logic        clk = 1'b0;
  logic        arst;
  logic        op_valid;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [63:0] op_c;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        busy;
  logic        drop;

  always #5 clk = ~clk;

  mac_unit #(
    .DW (DW)
  ) dut (
    .clk               (clk),
    .arst_i            (arst),
    .operation_valid_i (op_valid),
    .operand_a_i       (op_a),
    .operand_b_i       (op_b),
    .operand_c_i       (op_c),
    .wr_data_o         (wr_data),
    .wr_data_valid_o   (wr_valid),
    .wr_data_ready_i   (wr_ready),
    .busy_o            (busy),
    .drop_o            (drop)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: accepted words, valid rise times, drop pulses, hold violations.
  logic [31:0] got [0:511];
  int          rise [0:127];
  int          got_n    = 0;
  int          rise_n   = 0;
  int          drop_n   = 0;
  int          hold_bad = 0;
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [31:0] pd = '0;

  always @(negedge clk) begin
    if (arst) begin
      pv <= 1'b0;
    end else begin
      if (wr_valid && wr_ready) begin
        got[got_n] <= wr_data;
        got_n      <= got_n + 1;
      end
      if (wr_valid && !pv) begin
        rise[rise_n] <= cyc;
        rise_n       <= rise_n + 1;
      end
      if (drop) drop_n <= drop_n + 1;
      if (pv && !pr && (wr_valid !== 1'b1 || wr_data !== pd)) hold_bad <= hold_bad + 1;
      pv <= wr_valid;
    end
    pr <= wr_ready;
    pd <= wr_data;
  end

  logic [31:0] exp_q [$];
  int          last_op;
  bit          rand_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] mac_ref(input logic [31:0] xa, input logic [31:0] xb,
                                          input logic [63:0] xc);
    logic [63:0] wa;
    logic [63:0] wb;
    wa = {32'd0, xa};
    wb = {32'd0, xb};
    return wa * wb + xc;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) wr_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_op(input logic [31:0] xa, input logic [31:0] xb,
                         input logic [63:0] xc, input bit keep);
    logic [63:0] r;
    op_valid = 1'b1;
    op_a     = xa;
    op_b     = xb;
    op_c     = xc;
    tick();
    op_valid = 1'b0;
    last_op  = cyc;
    if (keep) begin
      r = mac_ref(xa, xb, xc);
      exp_q.push_back(r[63:32]);
      exp_q.push_back(r[31:0]);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_words(input string tag, input int target, input int budget);
    int k = 0;
    while (got_n < target && k < budget) begin
      tick();
      k++;
    end
    check(tag, 64'(got_n >= target), 64'd1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    check(tag, 64'(busy), 64'd0);
  endtask

  task automatic compare_words(input string tag, input int base);
    check({tag, "_count"}, 64'(got_n - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && base + i < got_n; i++) begin
      check(tag, 64'(got[base + i]), 64'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int rb;
    int d0;
    int e0;
    int nw;
    logic [31:0] ra;
    logic [31:0] rbv;
    logic [63:0] rc;

    arst     = 1'b1;
    op_valid = 1'b0;
    op_a     = '0;
    op_b     = '0;
    op_c     = '0;
    wr_ready = 1'b1;
    idle(2);
    check("rst_data",  64'(wr_data),  64'd0);
    check("rst_valid", 64'(wr_valid), 64'd0);
    check("rst_busy",  64'(busy),     64'd0);
    check("rst_drop",  64'(drop),     64'd0);
    arst = 1'b0;
    idle(2);

    // Basic
    base = got_n;
    rb   = rise_n;
    send_op(32'd3, 32'd5, 64'd7, 1'b1);
    e0 = last_op;
    check("basic_busy_hi", 64'(busy), 64'd1);
    wait_words("basic_wait", base + 2, 100);
    check("basic_latency", 64'(rise[rb]), 64'(e0 + DW + 2));
    compare_words("basic", base);
    check("basic_busy_lo", 64'(busy), 64'd0);
    idle(2);

    // Wrap
    base = got_n;
    send_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    wait_words("wrap_wait", base + 2, 100);
    compare_words("wrap", base);
    wait_idle("wrap_idle", 10);

    // Backpressure
    wr_ready = 1'b0;
    base = got_n;
    rb   = rise_n;
    send_op(32'd2, 32'd4, 64'h1_0000_0001, 1'b1);
    begin
      int k = 0;
      while (rise_n == rb && k < 100) begin
        tick();
        k++;
      end
    end
    check("bp_rise", 64'(rise_n > rb), 64'd1);
    idle(10);
    check("bp_nowords", 64'(got_n - base), 64'd0);
    check("bp_valid_held", 64'(wr_valid), 64'd1);
    wr_ready = 1'b1;
    wait_words("bp_wait", base + 2, 20);
    compare_words("bp", base);
    check("bp_hold", 64'(hold_bad), 64'd0);
    wait_idle("bp_idle", 10);

    // Pending and drop
    base = got_n;
    rb   = rise_n;
    d0   = drop_n;
    send_op(32'h1234_5678, 32'h9ABC_DEF0, 64'h11, 1'b1);
    e0 = last_op;
    idle(3);
    send_op(32'hDEAD_BEEF, 32'd77, 64'hFFFF_0000_0000_0000, 1'b1);
    idle(3);
    send_op(32'd1, 32'd1, 64'd1, 1'b0);
    wait_words("pend_wait", base + 4, 200);
    check("pend_first_lat", 64'(rise[rb]), 64'(e0 + DW + 2));
    check("pend_spacing", 64'(rise[rb + 1] - rise[rb]), 64'(DW + 4));
    compare_words("pend", base);
    check("pend_drop", 64'(drop_n - d0), 64'd1);
    wait_idle("pend_idle", 10);

    // Simultaneous consume + store on the final SEND_LO handshake
    base = got_n;
    rb   = rise_n;
    d0   = drop_n;
    send_op(32'd10, 32'd20, 64'd30, 1'b1);
    e0 = last_op;
    idle(3);
    send_op(32'd40, 32'd50, 64'd60, 1'b1);
    idle(31);
    send_op(32'd70, 32'd80, 64'd90, 1'b1);
    check("simul_op_edge", 64'(last_op - e0), 64'(DW + 4));
    wait_words("simul_wait", base + 6, 300);
    check("simul_second", 64'(rise[rb + 1]), 64'(e0 + 2 * DW + 6));
    check("simul_third", 64'(rise[rb + 2] - rise[rb + 1]), 64'(DW + 4));
    compare_words("simul", base);
    check("simul_nodrop", 64'(drop_n - d0), 64'd0);
    wait_idle("simul_idle", 10);

    // Reset mid-MUL
    base = got_n;
    send_op(32'd9, 32'd9, 64'd1, 1'b0);
    idle(9);
    arst = 1'b1;
    #1;
    check("mrst_busy",  64'(busy),     64'd0);
    check("mrst_valid", 64'(wr_valid), 64'd0);
    check("mrst_data",  64'(wr_data),  64'd0);
    check("mrst_drop",  64'(drop),     64'd0);
    idle(2);
    arst = 1'b0;
    idle(50);
    check("mrst_nowords", 64'(got_n - base), 64'd0);
    send_op(32'd6, 32'd7, 64'd0, 1'b1);
    wait_words("mrst_wait", base + 2, 100);
    compare_words("mrst", base);
    wait_idle("mrst_idle", 10);

    // Randomized operands, random ready, occasional pending op
    rand_ready = 1'b1;
    d0 = drop_n;
    for (int it = 0; it < 12; it++) begin
      base = got_n;
      ra   = (it == 0) ? 32'd0 : $urandom;
      rbv  = (it == 1) ? 32'hFFFF_FFFF : $urandom;
      rc   = {$urandom, $urandom};
      send_op(ra, rbv, rc, 1'b1);
      nw = 2;
      if ($urandom_range(0, 1) == 1) begin
        idle($urandom_range(1, 20));
        send_op($urandom, $urandom, {$urandom, $urandom}, 1'b1);
        nw = 4;
      end
      wait_words("rand_wait", base + nw, 800);
      wait_idle("rand_idle", 50);
      compare_words("rand", base);
    end
    rand_ready = 1'b0;
    wr_ready   = 1'b1;
    check("rand_nodrop", 64'(drop_n - d0), 64'd0);
    check("hold_total", 64'(hold_bad), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
